ram_bist_controller: RTL and testbench

- Initiator-side engine that drives the write/read ports of the 16x8 synchronous dual-port RAM (ram_16x8_synchronous) and checks what comes back.
- On a start pulse it writes a pattern to every address, reads it back and compares, then repeats with the inverted pattern.
- Reports pass/fail, the first failing address and data, and an error count.
- Sits beside the RAM as its power-on/self-test master; the functional datapath is muxed onto the RAM ports while busy=0.

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_bist_controller_checker.sv | 89 ++++++++
 rtl/ram_bist_controller.sv | 173 +++++++++++++++++
 tb/tb_ram_bist_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM self-test slice: default RAM geometry,
// the base test pattern and the BIST sequencer state encoding.
package ram_pkg;

  localparam int              RAM_WIDTH   = 8;
  localparam int              RAM_DEPTH   = 16;
  localparam int              RAM_ADDR_W  = 4;
  localparam int              RAM_ERR_W   = 6;
  localparam logic [7:0]      RAM_PATTERN = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR0   = 3'd1,
    RD0   = 3'd2,
    WR1   = 3'd3,
    RD1   = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } bist_state_t;

endpackage

// File: rtl/ram_bist_controller_checker.sv
// bist_checker: one-stage compare pipeline behind the RAM read port.
// A read issued in cycle N returns data in cycle N+1; the expected value and
// address are staged here so the compare lines up with the returned data.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clr             synchronous clear at the start of a run
//   issue           a read is on the RAM port this cycle
//   exp_in/addr_in  expected data and address of that read
//   rd_data         RAM read data (valid the cycle after issue)
//   mismatch        current compare failed (combinational)
//   fail_addr/data  first mismatch of the run
//   err_count       saturating mismatch count
module bist_checker #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              issue,
  input  logic [WIDTH-1:0]  exp_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              mismatch,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output logic [ERR_W-1:0]  err_count
);

  logic              cmp_valid_r;
  logic [WIDTH-1:0]  exp_r;
  logic [ADDR_W-1:0] cmp_addr_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [WIDTH-1:0]  fail_data_r;
  logic [ERR_W-1:0]  err_count_r;
  logic              mismatch_s;

  // Compare the staged expectation against the data the RAM returned.
  always_comb begin
    mismatch_s = cmp_valid_r && (rd_data != exp_r);
  end

  // Pipeline stage, saturating error counter and first-fail capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_valid_r <= 1'b0;
      exp_r       <= '0;
      cmp_addr_r  <= '0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
      err_count_r <= '0;
    end else if (clr) begin
      cmp_valid_r <= 1'b0;
      exp_r       <= '0;
      cmp_addr_r  <= '0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
      err_count_r <= '0;
    end else begin
      cmp_valid_r <= issue;
      exp_r       <= exp_in;
      cmp_addr_r  <= addr_in;
      if (mismatch_s) begin
        // A zero count means no earlier mismatch in this run.
        if (err_count_r == {ERR_W{1'b0}}) begin
          fail_addr_r <= cmp_addr_r;
          fail_data_r <= rd_data;
        end else begin
          fail_addr_r <= fail_addr_r;
          fail_data_r <= fail_data_r;
        end
        if (err_count_r != {ERR_W{1'b1}}) begin
          err_count_r <= err_count_r + ERR_W'(1);
        end else begin
          err_count_r <= err_count_r;
        end
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign mismatch  = mismatch_s;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;
  assign err_count = err_count_r;

endmodule

// File: rtl/ram_bist_controller.sv
// ram_bist_controller: self-test master for the 16x8 synchronous dual-port RAM.
// On start it writes PATTERN^addr to every word, reads back and compares,
// then repeats with the inverted pattern, and reports pass/fail.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   start                   run request, sampled only in IDLE
//   ram_we/ram_re           RAM strobes (never both high)
//   ram_wr_addr/ram_rd_addr RAM addresses (inactive one holds)
//   ram_data_in             RAM write data
//   ram_data_out            RAM read data, one cycle after ram_re
//   busy, done              run in progress / one-cycle completion pulse
//   pass, fail_addr, fail_data, err_count  result of the last run
module ram_bist_controller
  import ram_pkg::*;
#(
  parameter int              WIDTH   = RAM_WIDTH,
  parameter int              DEPTH   = RAM_DEPTH,
  parameter int              ADDR_W  = RAM_ADDR_W,
  parameter logic [WIDTH-1:0] PATTERN = RAM_PATTERN,
  parameter int              ERR_W   = RAM_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [WIDTH-1:0]  ram_data_in,
  input  logic [WIDTH-1:0]  ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bist_state_t       state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              clr_s, nxt_wr_s, nxt_rd_s, nxt_busy_s;
  logic              ram_we_r, ram_re_r, busy_r, done_r, pass_r;
  logic [ADDR_W-1:0] ram_wr_addr_r, ram_rd_addr_r;
  logic [WIDTH-1:0]  ram_data_in_r, exp_s;
  logic              mismatch_s;
  logic [ERR_W-1:0]  err_count_s;

  function automatic logic [WIDTH-1:0] gen_data(input logic inv, input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] d;
    d = PATTERN ^ WIDTH'(a);
    if (inv) begin
      gen_data = ~d;
    end else begin
      gen_data = d;
    end
  endfunction

  // Next-state and address sequencing; strobes are derived from the next state
  // so that every RAM-facing output comes straight from a flop.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    clr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = WR0;
          addr_nxt_s  = '0;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR0, RD0, WR1, RD1: begin
        addr_nxt_s = addr_r + ADDR_W'(1);
        if (addr_r == LAST_ADDR) begin
          addr_nxt_s = '0;
          case (state_r)
            WR0:     state_nxt_s = RD0;
            RD0:     state_nxt_s = WR1;
            WR1:     state_nxt_s = RD1;
            RD1:     state_nxt_s = DRAIN;
            default: state_nxt_s = IDLE;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      DRAIN:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    nxt_wr_s   = (state_nxt_s == WR0) || (state_nxt_s == WR1);
    nxt_rd_s   = (state_nxt_s == RD0) || (state_nxt_s == RD1);
    nxt_busy_s = nxt_wr_s || nxt_rd_s || (state_nxt_s == DRAIN);
    // Expected value of the read currently on the RAM port.
    exp_s      = gen_data(state_r == RD1, ram_rd_addr_r);
  end

  // State, address counter and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      addr_r        <= '0;
      ram_we_r      <= 1'b0;
      ram_re_r      <= 1'b0;
      ram_wr_addr_r <= '0;
      ram_rd_addr_r <= '0;
      ram_data_in_r <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      addr_r   <= addr_nxt_s;
      ram_we_r <= nxt_wr_s;
      ram_re_r <= nxt_rd_s;
      busy_r   <= nxt_busy_s;
      done_r   <= (state_nxt_s == DONE);
      if (nxt_wr_s) begin
        ram_wr_addr_r <= addr_nxt_s;
        ram_data_in_r <= gen_data(state_nxt_s == WR1, addr_nxt_s);
      end else begin
        ram_wr_addr_r <= ram_wr_addr_r;
        ram_data_in_r <= ram_data_in_r;
      end
      if (nxt_rd_s) begin
        ram_rd_addr_r <= addr_nxt_s;
      end else begin
        ram_rd_addr_r <= ram_rd_addr_r;
      end
      // The final compare resolves on the same edge that enters DONE.
      if (clr_s) begin
        pass_r <= 1'b0;
      end else if (state_nxt_s == DONE) begin
        pass_r <= (err_count_s == {ERR_W{1'b0}}) && !mismatch_s;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  bist_checker #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .ERR_W  (ERR_W)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .issue     (ram_re_r),
    .exp_in    (exp_s),
    .addr_in   (ram_rd_addr_r),
    .rd_data   (ram_data_out),
    .mismatch  (mismatch_s),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .err_count (err_count_s)
  );

  assign ram_we      = ram_we_r;
  assign ram_re      = ram_re_r;
  assign ram_wr_addr = ram_wr_addr_r;
  assign ram_rd_addr = ram_rd_addr_r;
  assign ram_data_in = ram_data_in_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_count   = err_count_s;

endmodule

// File: tb/tb_ram_bist_controller.sv
// Directed bench for ram_bist_controller with a behavioural 16x8 RAM that can
// inject a stuck-at bit on one address or an address-aliasing write fault.
module tb_ram_bist_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ram_we, ram_re, busy, done, pass;
  logic [3:0] ram_wr_addr, ram_rd_addr, fail_addr;
  logic [7:0] ram_data_in, fail_data;
  logic [7:0] ram_data_out = 8'h00;
  logic [5:0] err_count;

  int total = 0;
  int bad   = 0;
  int fault_mode = 0;  // 0 none, 1 bit0 stuck-0 at addr 11, 2 addr7 writes alias to addr3

  int   first_busy, last_busy, done_cyc, done_pulses, nwr, nrd;
  bit   overlap;
  logic pass_at_done;
  logic [7:0] wlog [32];
  logic [3:0] walog [32];
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  ram_bist_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data),
    .err_count    (err_count)
  );

  // Behavioural synchronous RAM with optional fault injection.
  always @(posedge clk) begin
    logic [7:0] d;
    if (ram_we) begin
      mem[ram_wr_addr] <= ram_data_in;
      if (fault_mode == 2 && ram_wr_addr == 4'd7) mem[3] <= ram_data_in;
    end
    if (ram_re) begin
      d = mem[ram_rd_addr];
      if (fault_mode == 1 && ram_rd_addr == 4'd11) d[0] = 1'b0;
      ram_data_out <= d;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is accepted at edge 0, then sample cycles 1..ncyc at
  // 1ns after each edge. restart_cyc re-asserts start for one cycle.
  task automatic run_bist(input int ncyc, input int restart_cyc);
    first_busy = 0; last_busy = 0; done_cyc = 0; done_pulses = 0;
    nwr = 0; nrd = 0; overlap = 1'b0; pass_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (busy) begin
        if (first_busy == 0) first_busy = c;
        last_busy = c;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc == 0) begin
          done_cyc = c;
          pass_at_done = pass;
        end
      end
      if (ram_we && ram_re) overlap = 1'b1;
      if (ram_we) begin
        if (nwr < 32) begin
          wlog[nwr]  = ram_data_in;
          walog[nwr] = ram_wr_addr;
        end
        nwr++;
      end
      if (ram_re) nrd++;
      start = (c == restart_cyc) ? 1'b1 : 1'b0;
      if (c < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held low.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail_addr", fail_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Fault-free run: timing, access counts and write stream.
    fault_mode = 0;
    run_bist(80, 0);
    chk("ok_first_busy", first_busy, 1);
    chk("ok_last_busy", last_busy, 65);
    chk("ok_done_cyc", done_cyc, 66);
    chk("ok_done_pulses", done_pulses, 1);
    chk("ok_writes", nwr, 32);
    chk("ok_reads", nrd, 32);
    chk("ok_overlap", overlap, 0);
    chk("ok_pass_at_done", pass_at_done, 1);
    chk("ok_pass", pass, 1);
    chk("ok_err", err_count, 0);
    chk("wr0_addr11", walog[11], 11);
    chk("wr0_data11", wlog[11], 8'hAE);
    chk("wr0_data15", wlog[15], 8'hAA);
    chk("wr1_data0", wlog[16], 8'h5A);
    chk("wr1_addr11", walog[27], 11);
    chk("wr1_data11", wlog[27], 8'h51);

    // Bit0 stuck at 0 on reads of addr 11: only the RD1 compare fails.
    fault_mode = 1;
    run_bist(80, 0);
    chk("stuck_done_cyc", done_cyc, 66);
    chk("stuck_pass", pass, 0);
    chk("stuck_err", err_count, 1);
    chk("stuck_fail_addr", fail_addr, 11);
    chk("stuck_fail_data", fail_data, 8'h50);

    // Writes to addr 7 also land at addr 3: both passes fail at addr 3.
    fault_mode = 2;
    run_bist(80, 0);
    chk("alias_pass", pass, 0);
    chk("alias_err", err_count, 2);
    chk("alias_fail_addr", fail_addr, 3);
    chk("alias_fail_data", fail_data, 8'hA2);

    // start re-asserted mid-run is ignored; previous results are cleared.
    fault_mode = 0;
    run_bist(80, 10);
    chk("restart_done_cyc", done_cyc, 66);
    chk("restart_done_pulses", done_pulses, 1);
    chk("restart_writes", nwr, 32);
    chk("restart_reads", nrd, 32);
    chk("restart_pass", pass, 1);
    chk("restart_err", err_count, 0);
    chk("restart_fail_addr", fail_addr, 0);

    // Asynchronous reset in cycle 20 (RD0), checked before any clock edge.
    run_bist(20, 0);
    chk("pre_rst_re", ram_re, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_re", ram_re, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err", err_count, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_we", ram_we, 0);
    chk("post_rst_idle_done", done, 0);
    run_bist(80, 0);
    chk("post_rst_done_cyc", done_cyc, 66);
    chk("post_rst_writes", nwr, 32);
    chk("post_rst_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
